// File: rtl/intt_sequencer_if.sv
// intt_sequencer_if: control and address bundle between the inverse-NTT
// sequencer and the coefficient RAM / twiddle ROM / butterfly datapath.
// The stall input exists only when INTT_STALL_EN is defined.
interface intt_sequencer_if #(
    parameter int LOG_N = 10
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_a;
    logic [LOG_N-1:0] rd_addr_b;
    logic [LOG_N-2:0] tw_addr;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_a;
    logic [LOG_N-1:0] wr_addr_b;
    logic [LOG_N-1:0] stage;
`ifdef INTT_STALL_EN
    logic             stall;

    modport master (
        input  start, stall,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
        output start, stall,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );
`else
    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );
`endif
endinterface

// File: rtl/intt_sequencer.sv
// intt_sequencer: address/control sequencer for an in-place Gentleman-Sande
// inverse NTT. Issues one butterfly per cycle, walks all LOG_N stages with a
// drain gap of D = RD_LATENCY + BF_LATENCY cycles between them, and replays
// the read addresses D cycles later as write-back addresses.
// Optional feature macro: INTT_STALL_EN (adds a stall input that freezes
// issue and drain counting while the write-back delay line keeps moving).
module intt_sequencer #(
    parameter int LOG_N      = 10,
    parameter int RD_LATENCY = 1,
    parameter int BF_LATENCY = 6
) (
    input  logic               clk,
    input  logic               rst,
    intt_sequencer_if.master   bus
);
    localparam int D  = RD_LATENCY + BF_LATENCY;
    localparam int DW = $clog2(D) + 1;
    localparam logic [LOG_N-1:0] K_LAST = LOG_N'((1 << (LOG_N - 1)) - 1);
    localparam logic [LOG_N-1:0] S_LAST = LOG_N'(LOG_N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(D - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    // Registered sequencer position: what the current cycle is doing.
    // act is low for a cycle that is frozen by stall.
    state_t           state, state_n;
    logic [LOG_N-1:0] s, s_n;
    logic [LOG_N-1:0] k, k_n;
    logic [DW-1:0]    dcnt, dcnt_n;
    logic             act, act_n;
    logic             stall_in;

    // Values the outputs will take in the next cycle
    logic             rd_en_n, busy_n, done_n;
    logic [LOG_N-1:0] addr_a_n, addr_b_n, tw_full_n, m_n, t_n;

    // Write-back delay line, one slot per cycle of read+butterfly latency
    logic             dl_en [D];
    logic [LOG_N-1:0] dl_a  [D];
    logic [LOG_N-1:0] dl_b  [D];

`ifdef INTT_STALL_EN
    assign stall_in = bus.stall;
`else
    assign stall_in = 1'b0;
`endif

    // State register: FSM state plus stage, butterfly and drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            dcnt  <= '0;
            act   <= 1'b1;
        end else begin
            state <= state_n;
            s     <= s_n;
            k     <= k_n;
            dcnt  <= dcnt_n;
            act   <= act_n;
        end
    end

    // Next-state logic: a cycle frozen by stall leaves the position untouched
    always_comb begin
        state_n = state;
        s_n     = s;
        k_n     = k;
        dcnt_n  = dcnt;
        act_n   = !stall_in;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ISSUE;
                    s_n     = '0;
                    k_n     = '0;
                end
            end
            ISSUE: begin
                if (act) begin
                    if (k == K_LAST) begin
                        state_n = DRAIN;
                        dcnt_n  = '0;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (act) begin
                    if (dcnt == D_LAST) begin
                        if (s == S_LAST) begin
                            state_n = FINISH;
                        end else begin
                            state_n = ISSUE;
                            s_n     = s + 1'b1;
                            k_n     = '0;
                        end
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode from the next position so every output leaves a flop
    always_comb begin
        rd_en_n   = (state_n == ISSUE) && act_n;
        busy_n    = (state_n == ISSUE) || (state_n == DRAIN);
        done_n    = (state_n == FINISH);
        m_n       = LOG_N'(1) << s_n;
        t_n       = k_n & (m_n - 1'b1);
        addr_a_n  = '0;
        addr_b_n  = '0;
        tw_full_n = '0;
        if (rd_en_n) begin
            addr_a_n  = ((k_n >> s_n) << (s_n + 1'b1)) | t_n;
            addr_b_n  = addr_a_n + m_n;
            tw_full_n = t_n << (S_LAST - s_n);
        end
    end

    // Output registers and the write-back delay line, all cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr_a <= '0;
            bus.rd_addr_b <= '0;
            bus.tw_addr   <= '0;
            bus.stage     <= '0;
            for (int i = 0; i < D; i++) begin
                dl_en[i] <= 1'b0;
                dl_a[i]  <= '0;
                dl_b[i]  <= '0;
            end
        end else begin
            bus.busy      <= busy_n;
            bus.done      <= done_n;
            bus.rd_en     <= rd_en_n;
            bus.rd_addr_a <= addr_a_n;
            bus.rd_addr_b <= addr_b_n;
            bus.tw_addr   <= tw_full_n[LOG_N-2:0];
            bus.stage     <= s_n;
            dl_en[0]      <= bus.rd_en;
            dl_a[0]       <= bus.rd_addr_a;
            dl_b[0]       <= bus.rd_addr_b;
            for (int i = 1; i < D; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a[i]  <= dl_a[i-1];
                dl_b[i]  <= dl_b[i-1];
            end
        end
    end

    assign bus.wr_en     = dl_en[D-1];
    assign bus.wr_addr_a = dl_a[D-1];
    assign bus.wr_addr_b = dl_b[D-1];
endmodule
